// File: rtl/player_memory_builder_if.sv
// ============================================================================
// Module      : player_memory_builder_if
// Description : Start/done handshake and key/table/image bus for the
//               player memory builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface player_memory_builder_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int DATA_W      = 8,
    parameter int TABLE_DEPTH = 36
);
    logic                              start;
    logic [NUM_PLAYERS*DATA_W-1:0]     private_keys;
    logic [TABLE_DEPTH*DATA_W-1:0]     random_table;
    logic [NUM_PLAYERS*3*DATA_W-1:0]   starting_memory;
    logic                              busy;
    logic                              done;
    logic                              mem_valid;

    modport master (
        output start, private_keys, random_table,
        input  starting_memory, busy, done, mem_valid
    );

    modport slave (
        input  start, private_keys, random_table,
        output starting_memory, busy, done, mem_valid
    );
endinterface

`default_nettype wire

// File: rtl/player_memory_builder.sv
// ============================================================================
// Module      : player_memory_builder
// Description : Sequential builder of the N-player starting memory image using
//               a shared, time-multiplexed Pearson-style hash datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_memory_builder #(
    parameter int NUM_PLAYERS = 2,
    parameter int DATA_W      = 8,
    parameter int TABLE_DEPTH = 36,
    parameter int ROUNDS      = 8,
    parameter int START_MONEY = 100
) (
    input  wire logic                clk_i,
    input  wire logic                rst_i,
    player_memory_builder_if.slave   bus_if
);
    localparam int IDX_W = DATA_W + 8;
    localparam int P_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int R_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int KEY_W = NUM_PLAYERS * DATA_W;
    localparam int IMG_W = NUM_PLAYERS * 3 * DATA_W;

    localparam logic [DATA_W-1:0] c_MONEY = DATA_W'(START_MONEY);
    localparam logic [IDX_W-1:0]  c_DEPTH = IDX_W'(TABLE_DEPTH);
    localparam logic [P_W-1:0]    c_LAST_P = P_W'(NUM_PLAYERS - 1);
    localparam logic [R_W-1:0]    c_LAST_R = R_W'(ROUNDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HASH = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [KEY_W-1:0]    keys_q,   keys_d;
    logic [P_W-1:0]      p_q,      p_d;
    logic [R_W-1:0]      r_q,      r_d;
    logic [DATA_W-1:0]   h_q,      h_d;
    logic [IMG_W-1:0]    shadow_q, shadow_d;
    logic [IMG_W-1:0]    mem_q,    mem_d;
    logic                valid_q,  valid_d;
    logic                done_q,   done_d;

    logic [DATA_W-1:0]   key_w;
    logic [IDX_W-1:0]    idx_sum_w;
    logic [IDX_W-1:0]    idx_mod_w;
    logic [DATA_W-1:0]   tbl_w;

    // Hash datapath: select current player's key, form index, look up table
    always_comb begin
        key_w = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (p_q == P_W'(i)) begin
                key_w = keys_q[(NUM_PLAYERS-1-i)*DATA_W +: DATA_W];
            end
        end
        idx_sum_w = {8'd0, h_q ^ key_w} + IDX_W'(r_q);
        idx_mod_w = idx_sum_w % c_DEPTH;
        tbl_w = '0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            if (idx_mod_w == IDX_W'(i)) begin
                tbl_w = bus_if.random_table[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        keys_d   = keys_q;
        p_d      = p_q;
        r_d      = r_q;
        h_d      = h_q;
        shadow_d = shadow_q;
        mem_d    = mem_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    keys_d  = bus_if.private_keys;
                    p_d     = '0;
                    r_d     = '0;
                    h_d     = '0;
                    state_d = S_HASH;
                end
            end
            S_HASH: begin
                if (r_q == c_LAST_R) begin
                    h_d = '0;
                    r_d = '0;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (p_q == P_W'(i)) begin
                            shadow_d[(NUM_PLAYERS-1-i)*3*DATA_W +: 3*DATA_W] =
                                {key_w, tbl_w, c_MONEY};
                        end
                    end
                    if (p_q == c_LAST_P) begin
                        // Publish the whole image at once, including the record just finished
                        p_d     = '0;
                        mem_d   = shadow_d;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end else begin
                    h_d = tbl_w;
                    r_d = r_q + R_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            keys_q   <= '0;
            p_q      <= '0;
            r_q      <= '0;
            h_q      <= '0;
            shadow_q <= '0;
            mem_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            keys_q   <= keys_d;
            p_q      <= p_d;
            r_q      <= r_d;
            h_q      <= h_d;
            shadow_q <= shadow_d;
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign bus_if.starting_memory = mem_q;
    assign bus_if.busy            = (state_q == S_HASH);
    assign bus_if.done            = done_q;
    assign bus_if.mem_valid       = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_player_memory_builder.sv
// ============================================================================
// Module      : tb_player_memory_builder
// Description : Scoreboard bench for player_memory_builder in three configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_memory_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] q2[$];

    logic [7:0] keys_m[4];
    logic [7:0] tbl_m[36];

    player_memory_builder_if #(.NUM_PLAYERS(2), .DATA_W(8), .TABLE_DEPTH(36)) if0();
    player_memory_builder_if #(.NUM_PLAYERS(2), .DATA_W(8), .TABLE_DEPTH(36)) if1();
    player_memory_builder_if #(.NUM_PLAYERS(4), .DATA_W(8), .TABLE_DEPTH(36)) if2();

    player_memory_builder u0 (.clk_i(clk), .rst_i(rst), .bus_if(if0.slave));
    player_memory_builder #(.ROUNDS(1)) u1 (.clk_i(clk), .rst_i(rst), .bus_if(if1.slave));
    player_memory_builder #(.NUM_PLAYERS(4), .START_MONEY(300)) u2 (
        .clk_i(clk), .rst_i(rst), .bus_if(if2.slave));

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference image built straight from the algorithm description
    function automatic logic [127:0] model(int n, int rounds, int depth, int money);
        logic [127:0] img = '0;
        for (int p = 0; p < n; p++) begin
            int h = 0;
            for (int r = 0; r < rounds; r++) begin
                h = int'(tbl_m[((h ^ int'(keys_m[p])) + r) % depth]);
            end
            img = (img << 24) | {104'd0, keys_m[p], 8'(h), 8'(money)};
        end
        return img;
    endfunction

    function automatic logic get_done(int w);
        case (w)
            0: return if0.done;
            1: return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic get_busy(int w);
        case (w)
            0: return if0.busy;
            1: return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    task automatic set_start(int w, logic v);
        case (w)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic load_all();
        for (int i = 0; i < 36; i++) begin
            if0.random_table[i*8 +: 8] = tbl_m[i];
        end
        if0.private_keys = {keys_m[0], keys_m[1]};
    endtask

    // Pulse start on DUT w, then measure latency and done width
    task automatic pulse_and_wait(int w, int exp_lat, string tag);
        int lat = 0;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        check_eq({tag, "_busy"}, 128'(get_busy(w)), 128'd1);
        while (!get_done(w) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, "_busy_at_done"}, 128'(get_busy(w)), 128'd0);
        @(negedge clk);
        check_eq({tag, "_done_width"}, 128'(get_done(w)), 128'd0);
    endtask

    always @(negedge clk) begin
        if (if0.done) begin
            check_eq("sb0_expected", 128'(q0.size() != 0), 128'd1);
            if (q0.size() != 0) check_eq("img0", 128'(if0.starting_memory), q0.pop_front());
        end
        if (if1.done) begin
            check_eq("sb1_expected", 128'(q1.size() != 0), 128'd1);
            if (q1.size() != 0) check_eq("img1", 128'(if1.starting_memory), q1.pop_front());
        end
        if (if2.done) begin
            check_eq("sb2_expected", 128'(q2.size() != 0), 128'd1);
            if (q2.size() != 0) check_eq("img2", 128'(if2.starting_memory), q2.pop_front());
        end
    end

    initial begin
        int lat;
        int ndone;
        logic stable_bad;
        logic [127:0] img_a;

        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tbl_m[i] = 8'hA5;
            if1.random_table[i*8 +: 8] = 8'(i);
            if2.random_table[i*8 +: 8] = 8'h3C;
        end
        keys_m[0] = 8'h75; keys_m[1] = 8'h1B;
        load_all();
        if1.private_keys = 16'h751B;
        if2.private_keys = 32'h11223344;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mem", 128'(if0.starting_memory), 128'd0);
        check_eq("rst_busy", 128'(if0.busy), 128'd0);
        check_eq("rst_done", 128'(if0.done), 128'd0);
        check_eq("rst_valid", 128'(if0.mem_valid), 128'd0);

        // Abort a build with reset held for three cycles
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 128'(if0.busy), 128'd0);
        check_eq("abort_valid", 128'(if0.mem_valid), 128'd0);
        check_eq("abort_mem", 128'(if0.starting_memory), 128'd0);
        repeat (20) @(negedge clk);
        check_eq("abort_idle_busy", 128'(if0.busy), 128'd0);

        // Default config, flat 0xA5 table
        q0.push_back(128'h75A5641BA564);
        pulse_and_wait(0, 16, "a5");
        check_eq("a5_valid", 128'(if0.mem_valid), 128'd1);
        check_eq("a5_mem_hold", 128'(if0.starting_memory), 128'h75A5641BA564);

        // Single round, identity table
        q1.push_back(128'h7509641B1B64);
        pulse_and_wait(1, 2, "r1");

        // Four players, money truncated to 0x2C
        q2.push_back(128'h113C2C_223C2C_333C2C_443C2C);
        pulse_and_wait(2, 32, "np4");

        // Start re-asserted mid-build and keys changed after capture
        for (int i = 0; i < 36; i++) tbl_m[i] = 8'($urandom);
        keys_m[0] = 8'h9E; keys_m[1] = 8'h44;
        load_all();
        q0.push_back(model(2, 8, 36, 100));
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        lat = 0;
        while (!if0.done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == 3 || lat == 10) if0.start = 1'b1;
            if (lat == 11) if0.start = 1'b0;
            if (lat == 4) begin
                if0.start = 1'b0;
                if0.private_keys = 16'hF00D;
            end
        end
        check_eq("restart_latency", 128'(lat), 128'd16);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (if0.done) ndone++;
        end
        check_eq("restart_no_second", 128'(ndone), 128'd0);
        check_eq("restart_idle", 128'(if0.busy), 128'd0);

        // Back-to-back builds: old image must stay stable until new done
        for (int i = 0; i < 36; i++) tbl_m[i] = 8'($urandom);
        keys_m[0] = 8'h3D; keys_m[1] = 8'hC2;
        load_all();
        img_a = model(2, 8, 36, 100);
        q0.push_back(img_a);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        lat = 0;
        while (!if0.done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b_first_latency", 128'(lat), 128'd16);
        keys_m[0] = 8'h5A; keys_m[1] = 8'h0F;
        if0.private_keys = 16'h5A0F;
        q0.push_back(model(2, 8, 36, 100));
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        check_eq("b2b_accepted", 128'(if0.busy), 128'd1);
        stable_bad = 1'b0;
        lat = 0;
        while (!if0.done && lat < 300) begin
            if (128'(if0.starting_memory) !== img_a || if0.mem_valid !== 1'b1) stable_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check_eq("b2b_old_stable", 128'(stable_bad), 128'd0);
        check_eq("b2b_second_latency", 128'(lat), 128'd16);
        check_eq("b2b_valid", 128'(if0.mem_valid), 128'd1);
        repeat (3) @(negedge clk);
        check_eq("sb_drained", 128'(q0.size() + q1.size() + q2.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/player_memory_builder.md
# player_memory_builder

Parametrised, sequential generator of the game's starting memory image for N players. For each player it derives a public key from the private key with a multi-round Pearson-style table hash, then packs {private, public, money} into one flat vector for the memory loader. It sits between the random-table source and the memory initialisation logic. Unlike the fixed two-player combinational packer, it has a start/done handshake, one shared hash datapath time-multiplexed across players, and runtime-supplied keys.

## Interface
- NUM_PLAYERS, 2, number of player records (>=1)
- DATA_W, 8, width of the key, hash and money fields
- TABLE_DEPTH, 36, entries in the random table (>=1)
- ROUNDS, 8, hash rounds per player (>=1)
- START_MONEY, 100, initial money per player, truncated to DATA_W
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to build memory; one-cycle pulse or level
- private_keys  in  NUM_PLAYERS*DATA_W  player 0 key in the MSBs
- random_table  in  TABLE_DEPTH*DATA_W  entry i at bits [i*DATA_W +: DATA_W]
- starting_memory  out  NUM_PLAYERS*3*DATA_W  player 0 record in the MSBs; each record is {private, public, money}
- busy  out  1  build in progress
- done  out  1  one-cycle completion pulse
- mem_valid  out  1  starting_memory holds a completed image

## Operation
- FSM states: IDLE, HASH. No separate DONE state; done is a registered pulse issued on the HASH->IDLE transition.
- IDLE: if start=1, capture private_keys into an internal register, clear player index p=0, round r=0, hash h=0, enter HASH. Otherwise hold.
- HASH, one round per cycle: h <= T[((h XOR key_p) + r) mod TABLE_DEPTH].
  - Evaluate the index in DATA_W+8 bits before the modulo, so there is no overflow.
  - T is random_table as sampled live. The table must stay stable while busy=1; that is the caller's obligation.
- After round ROUNDS-1, write the result into shadow record p as {key_p, h, START_MONEY}. Then clear h and r and increment p.
- After the last round of player NUM_PLAYERS-1:
  - copy the shadow image into starting_memory (atomic update);
  - set mem_valid=1, pulse done=1, return to IDLE.
- starting_memory changes only on that completion edge, or on reset. It never shows partial images.
- start while in HASH is ignored: not queued, no restart.
- Changes to private_keys after capture have no effect on the current build.
- start sampled on the same edge that done pulses is not seen, because the FSM is still in HASH. A start in the following cycle is accepted.
- A new build keeps mem_valid=1 and the previous image visible until the new image replaces it.

## Timing
- Reset values: starting_memory=0, busy=0, done=0, mem_valid=0, FSM=IDLE, all counters 0.
- Reset in mid-build aborts the build. Outputs return to reset values on the next edge, and the partial image is discarded.
- start is sampled at edge E0.
  - busy=1 from after E0 through E(N*R-1), where N=NUM_PLAYERS and R=ROUNDS.
  - At edge E(N*R): starting_memory is updated, done=1, busy=0.
  - done=0 again after E(N*R+1).
  - Latency is N*R cycles. The default is 16.
- Back-to-back builds: minimum start-to-start spacing is N*R+1 cycles.
- Counter r wraps at ROUNDS-1 and p wraps at NUM_PLAYERS-1. No other wrap-around exists.

## Test plan
- Reset, then idle: all outputs 0. Hold reset for 3 cycles during a build at cycle 5, then release: outputs 0, no done, busy 0.
- Defaults, every table entry 0xA5, keys {0x75, 0x1B}, one start pulse:
  - done exactly 16 cycles later, for 1 cycle;
  - starting_memory=0x75A5641BA564, mem_valid=1.
- ROUNDS=1, TABLE_DEPTH=36, T[i]=i, keys {0x75, 0x1B}:
  - public keys are 117 mod 36 = 0x09 and 27 mod 36 = 0x1B;
  - image 0x750964_1B1B64, latency 2.
- Start re-asserted at cycles 3 and 10 of a default build, and keys changed at cycle 4: done still at cycle 16, image is built from the original keys, no second build.
- NUM_PLAYERS=4, all entries 0x3C, START_MONEY=300: done after 32 cycles, each record {key_i, 0x3C, 0x2C}.
- Two builds with different keys: the old image stays stable and mem_valid stays 1 throughout the second build, then the image swaps on the second done edge only.
